// File: rtl/uarch_pkg.sv
`default_nettype none
// ============================================================================
// Package : uarch_pkg
// Brief   : Shared micro-architecture types for the LSU memory-execute stage.
// Rev     : 1.0  initial release
// ============================================================================
package uarch_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 6;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ   = 3'd1,
        LSU_WAIT  = 3'd2,
        LSU_WB    = 3'd3,
        LSU_DRAIN = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
    } operand_t;

    typedef struct packed {
        logic                  is_valid;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [TAG_WIDTH-1:0]  dest_tag;
        logic [DATA_WIDTH-1:0] agu_addr;
        operand_t              src_1;
    } instruction_t;

    typedef struct packed {
        logic                  is_valid;
        logic [TAG_WIDTH-1:0]  dest_tag;
        logic [DATA_WIDTH-1:0] result;
    } writeback_packet_t;

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_load_align
// Brief  : Extracts and sign/zero-extends load data from a raw memory word.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_load_align
    import uarch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lane uses only off[1]; a misaligned off[0] is ignored.
    assign w_byte = rdata[{off, 3'b000} +: 8];
    assign w_half = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   result = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, w_half};
            default: result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : lsu_mem_stage
// Brief  : Single-op memory-execute stage: dmem request, load align, CDB writeback.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_mem_stage
    import uarch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = TAG_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  instruction_t      execute_pkt,
    output logic              alu_rdy,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    output logic [3:0]        dmem_req_wstrb,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_resp_rdata,
    output writeback_packet_t wb_pkt,
    input  logic              wb_grant,
    output logic              cache_stall
);

    lsu_state_e        r_state;
    logic              r_is_store;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [TAG_W-1:0]  r_tag;
    writeback_packet_t r_wb;

    logic              w_is_store;
    logic [XLEN-1:0]   w_addr;
    logic [XLEN-1:0]   w_data;
    logic [3:0]        w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_result;

    assign w_is_store = (execute_pkt.opcode == OP_STORE);
    assign w_addr     = execute_pkt.agu_addr;
    assign w_data     = execute_pkt.src_1.data;

    // Lane placement; misaligned halfwords snap to the containing half.
    always_comb begin
        w_wstrb = 4'h0;
        w_wdata = '0;
        if (w_is_store) begin
            case (execute_pkt.funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << w_addr[1:0];
                    w_wdata = {4{w_data[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << {w_addr[1], 1'b0};
                    w_wdata = {2{w_data[15:0]}};
                end
                default: begin
                    w_wstrb = 4'hF;
                    w_wdata = w_data;
                end
            endcase
        end
    end

    lsu_load_align #(
        .XLEN   (XLEN)
    ) u_load_align (
        .rdata  (dmem_resp_rdata),
        .off    (r_off),
        .funct3 (r_f3),
        .result (w_load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= LSU_IDLE;
            r_is_store     <= 1'b0;
            r_f3           <= 3'd0;
            r_off          <= 2'd0;
            r_tag          <= '0;
            r_wb           <= '0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            dmem_req_wstrb <= 4'h0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (execute_pkt.is_valid && !flush) begin
                        r_is_store     <= w_is_store;
                        r_f3           <= execute_pkt.funct3;
                        r_off          <= w_addr[1:0];
                        r_tag          <= execute_pkt.dest_tag;
                        dmem_req_we    <= w_is_store;
                        dmem_req_addr  <= {w_addr[XLEN-1:2], 2'b00};
                        dmem_req_wdata <= w_wdata;
                        dmem_req_wstrb <= w_wstrb;
                        r_state        <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    // Stores are already committed, so flush never touches them.
                    if (dmem_req_ready) begin
                        if (r_is_store)
                            r_state <= LSU_IDLE;
                        else if (flush)
                            r_state <= LSU_DRAIN;
                        else
                            r_state <= LSU_WAIT;
                    end else if (!r_is_store && flush) begin
                        r_state <= LSU_IDLE;
                    end
                end
                LSU_WAIT: begin
                    if (dmem_resp_valid) begin
                        if (flush) begin
                            r_state <= LSU_IDLE;
                        end else begin
                            r_wb.is_valid <= 1'b1;
                            r_wb.dest_tag <= r_tag;
                            r_wb.result   <= w_load_result;
                            r_state       <= LSU_WB;
                        end
                    end else if (flush) begin
                        r_state <= LSU_DRAIN;
                    end
                end
                LSU_WB: begin
                    if (flush || wb_grant) begin
                        r_wb    <= '0;
                        r_state <= LSU_IDLE;
                    end
                end
                LSU_DRAIN: begin
                    if (dmem_resp_valid)
                        r_state <= LSU_IDLE;
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign alu_rdy        = (r_state == LSU_IDLE);
    assign dmem_req_valid = (r_state == LSU_REQ);
    assign cache_stall    = !r_is_store &&
                            ((r_state == LSU_REQ) || (r_state == LSU_WAIT) || (r_state == LSU_WB));
    assign wb_pkt         = r_wb;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu_mem_stage
// Brief  : Directed vector bench for lsu_mem_stage with flush/stall sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lsu_mem_stage;
    import uarch_pkg::*;

    logic              clk;
    logic              rst;
    logic              flush;
    instruction_t      execute_pkt;
    logic              alu_rdy;
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic              dmem_req_we;
    logic [31:0]       dmem_req_addr;
    logic [31:0]       dmem_req_wdata;
    logic [3:0]        dmem_req_wstrb;
    logic              dmem_resp_valid;
    logic [31:0]       dmem_resp_rdata;
    writeback_packet_t wb_pkt;
    logic              wb_grant;
    logic              cache_stall;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(
        .XLEN            (32),
        .TAG_W           (TAG_WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .execute_pkt     (execute_pkt),
        .alu_rdy         (alu_rdy),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .wb_pkt          (wb_pkt),
        .wb_grant        (wb_grant),
        .cache_stall     (cache_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic is_store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [5:0] tag);
        execute_pkt.is_valid   = 1'b1;
        execute_pkt.opcode     = is_store ? OP_STORE : OP_LOAD;
        execute_pkt.funct3     = f3;
        execute_pkt.dest_tag   = tag;
        execute_pkt.agu_addr   = addr;
        execute_pkt.src_1.data = data;
    endtask

    // Nominal flow: ready immediately, response one cycle after accept, grant at once.
    task automatic run_vec(input vec_t v, input logic [5:0] tag);
        @(negedge clk);
        check("idle_alu_rdy", {31'd0, alu_rdy}, 32'd1);
        issue(v.is_store, v.f3, v.addr, v.data, tag);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        execute_pkt.is_valid = 1'b0;
        check("req_valid", {31'd0, dmem_req_valid}, 32'd1);
        check("req_we", {31'd0, dmem_req_we}, {31'd0, v.is_store});
        check("req_addr", dmem_req_addr, {v.addr[31:2], 2'b00});
        check("req_stall", {31'd0, cache_stall}, {31'd0, !v.is_store});
        check("req_alu_rdy", {31'd0, alu_rdy}, 32'd0);
        if (v.is_store) begin
            check("req_wstrb", {28'd0, dmem_req_wstrb}, {28'd0, v.exp_strb});
            check("req_wdata", dmem_req_wdata, v.exp_wdata);
        end
        @(negedge clk);
        dmem_req_ready = 1'b0;
        check("post_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        if (v.is_store) begin
            check("st_done_rdy", {31'd0, alu_rdy}, 32'd1);
            check("st_no_wb", {31'd0, wb_pkt.is_valid}, 32'd0);
        end else begin
            check("wait_stall", {31'd0, cache_stall}, 32'd1);
            dmem_resp_valid = 1'b1;
            dmem_resp_rdata = v.rdata;
            @(negedge clk);
            dmem_resp_valid = 1'b0;
            check("wb_valid", {31'd0, wb_pkt.is_valid}, 32'd1);
            check("wb_tag", {26'd0, wb_pkt.dest_tag}, {26'd0, tag});
            check("wb_result", wb_pkt.result, v.exp_result);
            wb_grant = 1'b1;
            @(negedge clk);
            wb_grant = 1'b0;
            check("wb_cleared", {31'd0, wb_pkt.is_valid}, 32'd0);
            check("ld_done_rdy", {31'd0, alu_rdy}, 32'd1);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, F3_SW,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b1, F3_SB,  32'h0000_1003, 32'h0000_00A5, 32'h0, 4'h8, 32'hA5A5_A5A5, 32'h0};
        vecs[2]  = '{1'b1, F3_SH,  32'h0000_1006, 32'h1234_BEEF, 32'h0, 4'hC, 32'hBEEF_BEEF, 32'h0};
        vecs[3]  = '{1'b1, F3_SH,  32'h0000_1001, 32'h0000_CAFE, 32'h0, 4'h3, 32'hCAFE_CAFE, 32'h0};
        vecs[4]  = '{1'b1, F3_SB,  32'h0000_1001, 32'h0000_0042, 32'h0, 4'h2, 32'h4242_4242, 32'h0};
        vecs[5]  = '{1'b0, F3_LB,  32'h0000_2002, 32'h0, 32'h1280_FF00, 4'h0, 32'h0, 32'hFFFF_FF80};
        vecs[6]  = '{1'b0, F3_LBU, 32'h0000_2002, 32'h0, 32'h1280_FF00, 4'h0, 32'h0, 32'h0000_0080};
        vecs[7]  = '{1'b0, F3_LH,  32'h0000_2002, 32'h0, 32'h1280_FF00, 4'h0, 32'h0, 32'h0000_1280};
        vecs[8]  = '{1'b0, F3_LH,  32'h0000_2000, 32'h0, 32'h1280_FF00, 4'h0, 32'h0, 32'hFFFF_FF00};
        vecs[9]  = '{1'b0, F3_LHU, 32'h0000_2001, 32'h0, 32'h1280_FF00, 4'h0, 32'h0, 32'h0000_FF00};
        vecs[10] = '{1'b0, F3_LB,  32'h0000_2001, 32'h0, 32'h1280_FF00, 4'h0, 32'h0, 32'hFFFF_FFFF};
        vecs[11] = '{1'b0, F3_LW,  32'h0000_2007, 32'h0, 32'h89AB_CDEF, 4'h0, 32'h0, 32'h89AB_CDEF};

        rst             = 1'b1;
        flush           = 1'b0;
        execute_pkt     = '0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        wb_grant        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_alu_rdy", {31'd0, alu_rdy}, 32'd1);
        check("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("rst_we", {31'd0, dmem_req_we}, 32'd0);
        check("rst_addr", dmem_req_addr, 32'd0);
        check("rst_wdata", dmem_req_wdata, 32'd0);
        check("rst_wstrb", {28'd0, dmem_req_wstrb}, 32'd0);
        check("rst_wb", {31'd0, wb_pkt.is_valid}, 32'd0);
        check("rst_stall", {31'd0, cache_stall}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i], 6'(i + 1));

        // LW tag 7: memory stalls the request, then answers late, arbiter grants late.
        @(negedge clk);
        issue(1'b0, F3_LW, 32'h0000_3008, 32'h0, 6'd7);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            execute_pkt.is_valid = 1'b0;
            check("stall_req_valid", {31'd0, dmem_req_valid}, 32'd1);
            check("stall_req_addr", dmem_req_addr, 32'h0000_3008);
            check("stall_req_we", {31'd0, dmem_req_we}, 32'd0);
            check("stall_cs", {31'd0, cache_stall}, 32'd1);
            check("stall_rdy", {31'd0, alu_rdy}, 32'd0);
        end
        dmem_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dmem_req_ready = 1'b0;
            check("lw_wait_cs", {31'd0, cache_stall}, 32'd1);
            check("lw_wait_rdy", {31'd0, alu_rdy}, 32'd0);
            check("lw_wait_wb", {31'd0, wb_pkt.is_valid}, 32'd0);
            if (c == 3) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = 32'h0BAD_F00D;
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dmem_resp_valid = 1'b0;
            check("lw_wb_valid", {31'd0, wb_pkt.is_valid}, 32'd1);
            check("lw_wb_tag", {26'd0, wb_pkt.dest_tag}, 32'd7);
            check("lw_wb_result", wb_pkt.result, 32'h0BAD_F00D);
            check("lw_wb_rdy", {31'd0, alu_rdy}, 32'd0);
            check("lw_wb_cs", {31'd0, cache_stall}, 32'd1);
            if (c == 2) wb_grant = 1'b1;
        end
        @(negedge clk);
        wb_grant = 1'b0;
        check("lw_after_grant_rdy", {31'd0, alu_rdy}, 32'd1);
        check("lw_after_grant_wb", {31'd0, wb_pkt.is_valid}, 32'd0);
        check("lw_after_grant_cs", {31'd0, cache_stall}, 32'd0);

        // Load flushed while waiting: the late response must be swallowed.
        issue(1'b0, F3_LW, 32'h0000_4000, 32'h0, 6'd9);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        execute_pkt.is_valid = 1'b0;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        flush = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            flush = 1'b0;
            check("drain_rdy", {31'd0, alu_rdy}, 32'd0);
            check("drain_req", {31'd0, dmem_req_valid}, 32'd0);
            check("drain_wb", {31'd0, wb_pkt.is_valid}, 32'd0);
            check("drain_cs", {31'd0, cache_stall}, 32'd0);
        end
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        check("drain_done_rdy", {31'd0, alu_rdy}, 32'd1);
        check("drain_done_wb", {31'd0, wb_pkt.is_valid}, 32'd0);

        // Committed store survives a flush while the memory is not ready.
        issue(1'b1, F3_SW, 32'h0000_5000, 32'h5555_AAAA, 6'd3);
        @(negedge clk);
        execute_pkt.is_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("st_flush_valid", {31'd0, dmem_req_valid}, 32'd1);
        check("st_flush_wdata", dmem_req_wdata, 32'h5555_AAAA);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        check("st_flush_done", {31'd0, dmem_req_valid}, 32'd0);
        check("st_flush_rdy", {31'd0, alu_rdy}, 32'd1);
        run_vec(vecs[7], 6'd12);

        // Unaccepted load request is withdrawn by flush.
        issue(1'b0, F3_LW, 32'h0000_6000, 32'h0, 6'd4);
        @(negedge clk);
        execute_pkt.is_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("ld_withdrawn_req", {31'd0, dmem_req_valid}, 32'd0);
        check("ld_withdrawn_rdy", {31'd0, alu_rdy}, 32'd1);

        // Flush in IDLE blocks capture of a valid op.
        issue(1'b1, F3_SW, 32'h0000_7000, 32'h0, 6'd5);
        flush = 1'b1;
        @(negedge clk);
        execute_pkt.is_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush_block", {31'd0, dmem_req_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
